// File: rtl/registro_control_multi.sv
// Multi-channel accelerator control/status register: one word per channel with
// a start/ack handshake to the channel FSM, sticky W1C flags, a busy watchdog and an interrupt.
module registro_control_multi #(
  parameter int N_CH    = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int AW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_we,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic [N_CH-1:0]          fsm_start,
  input  logic [N_CH-1:0]          fsm_ack,
  input  logic [N_CH-1:0]          fsm_done,
  input  logic [N_CH-1:0]          fsm_we,
  input  logic [N_CH*DATA_W-1:0]   fsm_data,
  output logic                     irq
);

  localparam int DW = DATA_W - 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [31:0]       addr_ext;
  logic [DATA_W-1:0] words [N_CH];
  logic [N_CH-1:0]   start_v;
  logic [N_CH-1:0]   flag_v;
  logic              unused_wdata;

  assign addr_ext     = 32'(cpu_addr);
  assign unused_wdata = ^{cpu_wdata[7:5], cpu_wdata[1]};

  // Handshake: fsm_start[i] is a level request that stays up until the channel
  // FSM answers with a one-cycle fsm_ack[i]; request and ack transfer on the same
  // edge, after which the channel is BUSY until fsm_done[i] or a watchdog expiry.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          start_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;
    logic          ie_r;
    logic [DW-1:0] data_r;
    logic [CW-1:0] cnt_r;
    logic          cpu_sel;
    logic          ack_ok;
    logic          done_ok;
    logic          expire;
    logic          unused_lo;

    assign cpu_sel   = cpu_we && (addr_ext == i);
    assign ack_ok    = fsm_ack[i] & start_r;
    assign done_ok   = fsm_done[i] & busy_r;
    assign unused_lo = ^fsm_data[i*DATA_W +: 8];

    // A done on the expiry cycle takes precedence, so expiry requires no done.
    if (TIMEOUT > 0) begin : g_wd
      assign expire = busy_r & ~fsm_done[i] & (cnt_r == CW'(TIMEOUT - 1));
    end else begin : g_no_wd
      assign expire = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        start_r <= 1'b0;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
        err_r   <= 1'b0;
        ie_r    <= 1'b0;
        data_r  <= '0;
        cnt_r   <= '0;
      end else begin
        if (ack_ok) begin
          start_r <= 1'b0;
        end else if (cpu_sel) begin
          start_r <= cpu_wdata[0];
        end

        if (ack_ok) begin
          busy_r <= 1'b1;
        end else if (done_ok || expire) begin
          busy_r <= 1'b0;
        end

        if (ack_ok || !busy_r || done_ok || expire) begin
          cnt_r <= '0;
        end else if (cnt_r != CW'(TIMEOUT - 1)) begin
          cnt_r <= cnt_r + 1'b1;
        end

        // Sticky flags: a set on the same edge as a W1C wins.
        done_r <= (done_r & ~(cpu_sel & cpu_wdata[2])) | done_ok;
        err_r  <= (err_r  & ~(cpu_sel & cpu_wdata[3])) | expire;

        if (cpu_sel) begin
          ie_r <= cpu_wdata[4];
        end

        if (fsm_we[i]) begin
          data_r <= fsm_data[i*DATA_W + 8 +: DW];
        end else if (cpu_sel) begin
          data_r <= cpu_wdata[DATA_W-1:8];
        end
      end
    end

    assign words[i]   = {data_r, 3'b000, ie_r, err_r, done_r, busy_r, start_r};
    assign start_v[i] = start_r;
    assign flag_v[i]  = ie_r & (done_r | err_r);
  end

  assign fsm_start = start_v;

  always_comb begin
    cpu_rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (addr_ext == 32'(i)) begin
        cpu_rdata = words[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |flag_v;
    end
  end

endmodule

// File: tb/tb_registro_control_multi.sv
// Bench for registro_control_multi: directed handshake/priority scenarios followed
// by randomized traffic checked against a per-channel behavioural model.
module tb_registro_control_multi;

  localparam int N   = 3;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int AW  = 2;

  logic            clk;
  logic            rst;
  logic            cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic [DW-1:0]   cpu_rdata;
  logic [N-1:0]    fsm_start;
  logic [N-1:0]    fsm_ack;
  logic [N-1:0]    fsm_done;
  logic [N-1:0]    fsm_we;
  logic [N*DW-1:0] fsm_data;
  logic            irq;

  int n_pass  = 0;
  int n_total = 0;

  registro_control_multi #(
    .N_CH(N), .DATA_W(DW), .TIMEOUT(TO), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .fsm_start(fsm_start),
    .fsm_ack(fsm_ack), .fsm_done(fsm_done), .fsm_we(fsm_we),
    .fsm_data(fsm_data), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: register fields per channel, age = cycles spent busy
  bit        m_start [N];
  bit        m_busy  [N];
  bit        m_done  [N];
  bit        m_err   [N];
  bit        m_ie    [N];
  bit [23:0] m_data  [N];
  int        m_age   [N];
  bit        m_irq;

  function automatic logic [DW-1:0] exp_word(int a);
    if (a >= N) return '0;
    return {m_data[a], 3'b000, m_ie[a], m_err[a], m_done[a], m_busy[a], m_start[a]};
  endfunction

  function automatic logic [N-1:0] exp_start();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_start[c];
    return v;
  endfunction

  // one clock edge: model computes next state from the inputs now driven
  task automatic tick();
    bit        n_start [N];
    bit        n_busy  [N];
    bit        n_done  [N];
    bit        n_err   [N];
    bit        n_ie    [N];
    bit [23:0] n_data  [N];
    int        n_age   [N];
    bit        n_irq;
    n_irq = 1'b0;
    for (int c = 0; c < N; c++) begin
      bit cw, acc, dset, exp_t;
      n_irq = n_irq | (m_ie[c] & (m_done[c] | m_err[c]));
      cw    = cpu_we && (int'(cpu_addr) == c);
      acc   = fsm_ack[c] && m_start[c];
      dset  = fsm_done[c] && m_busy[c];
      exp_t = m_busy[c] && !fsm_done[c] && (m_age[c] == TO - 1);
      n_start[c] = acc ? 1'b0 : (cw ? cpu_wdata[0] : m_start[c]);
      n_busy[c]  = m_busy[c];
      n_age[c]   = m_busy[c] ? m_age[c] + 1 : 0;
      if (dset || exp_t) begin n_busy[c] = 1'b0; n_age[c] = 0; end
      if (acc) begin n_busy[c] = 1'b1; n_age[c] = 0; end
      n_done[c] = (m_done[c] && !(cw && cpu_wdata[2])) || dset;
      n_err[c]  = (m_err[c]  && !(cw && cpu_wdata[3])) || exp_t;
      n_ie[c]   = cw ? cpu_wdata[4] : m_ie[c];
      n_data[c] = fsm_we[c] ? fsm_data[c*DW + 8 +: 24] : (cw ? cpu_wdata[31:8] : m_data[c]);
      if (!rst) begin
        n_start[c] = 0; n_busy[c] = 0; n_done[c] = 0; n_err[c] = 0;
        n_ie[c] = 0; n_data[c] = '0; n_age[c] = 0;
      end
    end
    if (!rst) n_irq = 1'b0;
    @(posedge clk);
    m_start = n_start; m_busy = n_busy; m_done = n_done; m_err = n_err;
    m_ie = n_ie; m_data = n_data; m_age = n_age; m_irq = n_irq;
    #1;
  endtask

  // driver tasks
  task automatic cpu_write(int a, logic [DW-1:0] d);
    cpu_we = 1'b1; cpu_addr = AW'(a); cpu_wdata = d;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] ack, input logic [N-1:0] done);
    fsm_ack = ack; fsm_done = done;
    tick();
    fsm_ack = '0; fsm_done = '0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    rst = 1'b0; cpu_we = 1'b1; cpu_addr = 0; cpu_wdata = 32'hFFFF_FFFF;
    fsm_ack = '1; fsm_done = '1; fsm_we = '1; fsm_data = '1;
    tick(); tick();
    rst = 1'b1; cpu_we = 1'b0; fsm_ack = '0; fsm_done = '0; fsm_we = '0; fsm_data = '0;
    for (int k = 0; k < 3; k++) begin
      cpu_addr = (k == 2) ? AW'(3) : AW'(k);
      #1; rd = cpu_rdata;
      n_total++;
      if (rd !== '0) $display("FAIL reset_rdata addr=%0d got=%h exp=0", cpu_addr, rd);
      else n_pass++;
    end
    n_total++;
    if (fsm_start !== 3'b000) $display("FAIL reset_start got=%b exp=000", fsm_start);
    else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq);
    else n_pass++;
  endtask

  task automatic test_handshake();
    cpu_write(1, 32'h0000_1211);
    cpu_addr = 1;
    n_total++;
    if (fsm_start !== 3'b010) $display("FAIL hs_start got=%b exp=010", fsm_start);
    else n_pass++;
    pulse(3'b010, 3'b000);
    n_total++;
    if (cpu_rdata !== 32'h0000_1212) $display("FAIL hs_ack got=%h exp=00001212", cpu_rdata);
    else n_pass++;
    pulse(3'b000, 3'b010);
    n_total++;
    if (cpu_rdata !== 32'h0000_1214 || irq !== 1'b0)
      $display("FAIL hs_done rdata=%h irq=%b exp=00001214/0", cpu_rdata, irq);
    else n_pass++;
    tick();
    n_total++;
    if (irq !== 1'b1) $display("FAIL hs_irq_set got=%b exp=1", irq);
    else n_pass++;
    cpu_write(1, 32'h0000_0004);
    cpu_addr = 1;
    n_total++;
    if (cpu_rdata !== 32'h0 || irq !== 1'b1)
      $display("FAIL hs_clear rdata=%h irq=%b exp=00000000/1", cpu_rdata, irq);
    else n_pass++;
    tick();
    n_total++;
    if (irq !== 1'b0) $display("FAIL hs_irq_clr got=%b exp=0", irq);
    else n_pass++;
  endtask

  task automatic test_cancel();
    cpu_write(0, 32'h1);
    fsm_ack = 3'b001;
    cpu_write(0, 32'h0);
    fsm_ack = '0;
    cpu_addr = 0;
    n_total++;
    if (cpu_rdata !== 32'h2 || fsm_start[0] !== 1'b0)
      $display("FAIL cancel_vs_ack rdata=%h start=%b exp=00000002/0", cpu_rdata, fsm_start[0]);
    else n_pass++;
    pulse(3'b000, 3'b001);
    cpu_write(0, 32'h4);
    cpu_write(0, 32'h1);
    n_total++;
    if (fsm_start[0] !== 1'b1) $display("FAIL cancel_pend got=%b exp=1", fsm_start[0]);
    else n_pass++;
    cpu_write(0, 32'h0);
    cpu_addr = 0;
    n_total++;
    if (cpu_rdata !== 32'h0 || fsm_start[0] !== 1'b0)
      $display("FAIL cancel_noack rdata=%h start=%b exp=00000000/0", cpu_rdata, fsm_start[0]);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    logic [DW-1:0] e;
    cpu_write(0, 32'h1);
    pulse(3'b001, 3'b000);
    cpu_addr = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (k < 8) ? 32'h2 : 32'h8;
      n_total++;
      if (cpu_rdata !== e || fsm_start[0] !== 1'b0)
        $display("FAIL wd_expire k=%0d rdata=%h start=%b exp=%h/0", k, cpu_rdata, fsm_start[0], e);
      else n_pass++;
    end
    cpu_write(0, 32'h8);
    cpu_write(0, 32'h1);
    pulse(3'b001, 3'b000);
    for (int k = 1; k <= 7; k++) tick();
    pulse(3'b000, 3'b001);
    cpu_addr = 0;
    n_total++;
    if (cpu_rdata !== 32'h4) $display("FAIL wd_done_wins got=%h exp=00000004", cpu_rdata);
    else n_pass++;
    cpu_write(0, 32'h4);
  endtask

  task automatic test_data();
    fsm_we = 3'b001; fsm_data = {64'h0, 32'hABCD_EF00};
    cpu_write(0, 32'h1234_5611);
    fsm_we = 3'b000;
    cpu_addr = 0;
    n_total++;
    if (cpu_rdata !== 32'hABCD_EF11) $display("FAIL data_contend got=%h exp=abcdef11", cpu_rdata);
    else n_pass++;
    fsm_we = 3'b001; fsm_data = {64'h0, 32'h1234_56FF};
    tick();
    fsm_we = 3'b000;
    n_total++;
    if (cpu_rdata !== 32'h1234_5611 || fsm_start[0] !== 1'b1)
      $display("FAIL data_lowbyte rdata=%h start=%b exp=12345611/1", cpu_rdata, fsm_start[0]);
    else n_pass++;
    cpu_write(0, 32'h0);
  endtask

  task automatic test_back_to_back();
    cpu_write(1, 32'h11);
    pulse(3'b010, 3'b000);
    pulse(3'b000, 3'b010);
    cpu_write(1, 32'h11);
    pulse(3'b010, 3'b000);
    fsm_done = 3'b010;
    cpu_write(1, 32'h14);
    fsm_done = 3'b000;
    cpu_addr = 1;
    n_total++;
    if (cpu_rdata !== 32'h14 || irq !== 1'b1)
      $display("FAIL set_beats_clr rdata=%h irq=%b exp=00000014/1", cpu_rdata, irq);
    else n_pass++;
    tick();
    n_total++;
    if (irq !== 1'b1) $display("FAIL set_beats_clr_irq got=%b exp=1", irq);
    else n_pass++;
    cpu_write(1, 32'h4);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) != 0);
      cpu_we    = ($urandom_range(0, 9) < 3);
      cpu_addr  = AW'($urandom_range(0, 3));
      cpu_wdata = $urandom;
      for (int c = 0; c < N; c++) begin
        fsm_ack[c]  = ($urandom_range(0, 3) == 0);
        fsm_done[c] = ($urandom_range(0, 5) == 0);
        fsm_we[c]   = ($urandom_range(0, 6) == 0);
      end
      fsm_data = {$urandom, $urandom, $urandom};
      tick();
      n_total++;
      if (cpu_rdata !== exp_word(int'(cpu_addr)) || fsm_start !== exp_start() || irq !== m_irq)
        $display("FAIL rand n=%0d addr=%0d rdata=%h exp=%h start=%b exp=%b irq=%b exp=%b",
                 n, cpu_addr, cpu_rdata, exp_word(int'(cpu_addr)), fsm_start, exp_start(), irq, m_irq);
      else n_pass++;
    end
    rst = 1'b1; cpu_we = 1'b0; fsm_ack = '0; fsm_done = '0; fsm_we = '0;
  endtask

  initial begin
    rst = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    fsm_ack = '0; fsm_done = '0; fsm_we = '0; fsm_data = '0;
    test_reset();
    test_handshake();
    test_cancel();
    test_watchdog();
    test_data();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
